roic_stream_sequencer: RTL
==========================

ROIC_STREAM_SEQUENCER -- requirements
Module: roic_stream_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 12, number of ROIC readout channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 24, width of each of the A and B sample words.
REQ-003 SHALL have parameter CNT_W, default 16, width of the line-length and line-count configuration.
REQ-004 SHALL use one clock and a synchronous active-high reset; ports as below.
REQ-005 sys_clk  in  1  sole clock, all logic on rising edge.
REQ-006 sys_rst  in  1  synchronous active-high reset.
REQ-007 frame_start_req  in  1  single-cycle request to start one frame.
REQ-008 frame_abort  in  1  single-cycle request to abort the current frame.
REQ-009 dummy_frame  in  1  sampled at start; 1 = consume data, emit nothing.
REQ-010 max_h_count  in  CNT_W  samples per channel per line.
REQ-011 max_v_count  in  CNT_W  lines per frame.
REQ-012 ch_data_a / ch_data_b  in  NUM_CH x DATA_W  per-channel sample words.
REQ-013 ch_valid  in  NUM_CH  per-channel data-available flags.
REQ-014 data_read_req  out  NUM_CH  one-hot per-channel pop strobe, valid-ready style.
REQ-015 m_axis_tvalid / m_axis_tready  out / in  1  output stream handshake.
REQ-016 m_axis_tdata_a / m_axis_tdata_b  out  DATA_W  output sample words.
REQ-017 m_axis_tlast  out  1  last beat of a line.
REQ-018 m_axis_tuser  out  1  first beat of a frame.
REQ-019 frame_start_out / frame_done / frame_reset  out  1  single-cycle status pulses.
REQ-020 busy  out  1  high in every state other than IDLE.

Function
REQ-021 States SHALL be IDLE, LOAD, STREAM, DRAIN, DONE.
REQ-022 IDLE->LOAD SHALL occur on frame_start_req. frame_start_req SHALL be ignored in all other states.
REQ-023 LOAD SHALL last one cycle with the following actions:
- latch max_h_count, max_v_count and dummy_frame;
- pulse frame_start_out;
- zero channel, sample and line counters;
- go to DONE if either count is 0, else to STREAM.
REQ-024 Transfer rule: out_free = !m_axis_tvalid | m_axis_tready. In STREAM, data_read_req[cur_ch] = out_free & ch_valid[cur_ch]; all other bits 0.
REQ-025 A transfer SHALL occur on every cycle in which data_read_req is nonzero.
REQ-026 On a transfer, the output register SHALL take the ch_data_a/b[cur_ch] words and set m_axis_tvalid.
- Exception: in dummy mode the data is discarded and m_axis_tvalid stays 0.
REQ-027 On a transfer, m_axis_tuser SHALL be 1 only for the first beat of the frame (line 0, channel 0, sample 0).
REQ-028 On a transfer, m_axis_tlast SHALL be 1 only for the last beat of a line (channel NUM_CH-1, sample max_h_count-1).
REQ-029 Ordering per line SHALL be channel 0 samples 0..h-1, then channel 1, ..., then channel NUM_CH-1.
REQ-030 The sample counter SHALL wrap to 0 and advance the channel. The channel counter SHALL wrap to 0 and advance the line.
REQ-031 Latency: data SHALL appear on m_axis one cycle after its transfer.
REQ-032 m_axis_tvalid SHALL clear on an accepted beat with no new transfer in the same cycle.
REQ-033 Throughput: one beat per cycle when ch_valid and m_axis_tready are held high.
REQ-034 Stall: output data and flags SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0. data_read_req SHALL be 0 during the stall.
REQ-035 The transfer of the last beat of the last line SHALL move the block to DRAIN.
REQ-036 DRAIN SHALL go to DONE once m_axis_tvalid is 0, or when the pending beat is accepted.
REQ-037 DONE SHALL pulse frame_done for one cycle, then go to IDLE.
REQ-038 frame_abort in any non-IDLE state SHALL take priority over all other actions:
- clear m_axis_tvalid, tlast and tuser;
- force data_read_req to 0;
- pulse frame_reset next cycle;
- go to IDLE without frame_done.
REQ-039 frame_abort in IDLE SHALL be ignored.
REQ-040 frame_abort and frame_start_req in the same IDLE cycle: start SHALL win.
REQ-041 Configuration inputs SHALL have no effect after LOAD until the next frame.
REQ-042 ch_valid on non-selected channels SHALL be ignored.

Reset
REQ-043 While sys_rst=1, outputs SHALL be 0 and the state SHALL be IDLE:
- busy, data_read_req, m_axis_tvalid, m_axis_tlast, m_axis_tuser;
- frame_start_out, frame_done, frame_reset;
- m_axis_tdata_a, m_axis_tdata_b.
REQ-044 Reset mid-frame SHALL behave as REQ-043 and SHALL NOT pulse frame_reset or frame_done.

Verification
REQ-045 Nominal frame, NUM_CH=2, h=3, v=2, ch_valid=all-1, tready=1, start:
- 12 beats on consecutive cycles;
- tuser on beat 0;
- tlast on beats 5 and 11;
- beat order ch0 s0..2, ch1 s0..2, per line;
- frame_done 2 cycles after the last transfer.
REQ-046 Backpressure: tready=0 for 5 cycles at beat 4 -> beat 4 data stable for 5 cycles, data_read_req=0 during the stall, no beat lost or duplicated, 12 beats total.
REQ-047 Dummy frame, same configuration:
- 12 data_read_req pulses;
- m_axis_tvalid never 1;
- frame_start_out and frame_done each pulse once.
REQ-048 Zero configuration: h=0, v=5 -> LOAD, then DONE; no data_read_req, no tvalid; frame_done 2 cycles after start.
REQ-049 Abort at beat 7 with tready=0 and tvalid=1:
- next cycle tvalid=0 and frame_reset=1;
- busy=0;
- no frame_done;
- a new start then produces a full 12-beat frame with tuser on beat 0.
REQ-050 Start pulses during STREAM are ignored. sys_rst at beat 3 gives all-zero outputs with no frame_reset pulse.

Source files
------------

// File: rtl/roic_stream_sequencer.sv
// roic_stream_sequencer: walks the ROIC readout channels line by line, pops
// one sample per transfer from the selected channel and forwards the A/B words
// on a registered AXI-stream style output with frame/line markers.
module roic_stream_sequencer #(
    parameter int NUM_CH = 12,
    parameter int DATA_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           frame_start_req,
    input  logic                           frame_abort,
    input  logic                           dummy_frame,
    input  logic [CNT_W-1:0]               max_h_count,
    input  logic [CNT_W-1:0]               max_v_count,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_data_a,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_data_b,
    input  logic [NUM_CH-1:0]              ch_valid,
    output logic [NUM_CH-1:0]              data_read_req,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DATA_W-1:0]              m_axis_tdata_a,
    output logic [DATA_W-1:0]              m_axis_tdata_b,
    output logic                           m_axis_tlast,
    output logic                           m_axis_tuser,
    output logic                           frame_start_out,
    output logic                           frame_done,
    output logic                           frame_reset,
    output logic                           busy
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] h_lat;
    logic [CNT_W-1:0] v_lat;
    logic             dummy_lat;
    logic [CH_W-1:0]  ch_cnt;
    logic [CNT_W-1:0] smp_cnt;
    logic [CNT_W-1:0] line_cnt;

    logic out_free;
    logic xfer;
    logic abort_hit;
    logic last_smp;
    logic last_ch;
    logic last_line;

    // Transfer decision: selected channel has data and the output slot is free.
    always_comb begin
        out_free      = !m_axis_tvalid || m_axis_tready;
        abort_hit     = frame_abort && (state != IDLE);
        xfer          = (state == STREAM) && out_free && ch_valid[ch_cnt] && !frame_abort;
        data_read_req = xfer ? (NUM_CH'(1) << ch_cnt) : '0;
        last_smp      = (smp_cnt == h_lat - CNT_W'(1));
        last_ch       = (ch_cnt == LAST_CH);
        last_line     = (line_cnt == v_lat - CNT_W'(1));
    end

    // Status outputs decoded from the state; an abort in DONE suppresses frame_done.
    always_comb begin
        busy            = (state != IDLE);
        frame_start_out = (state == LOAD);
        frame_done      = (state == DONE) && !frame_abort;
    end

    // Frame FSM, configuration latch and sample/channel/line counters.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            h_lat       <= '0;
            v_lat       <= '0;
            dummy_lat   <= 1'b0;
            ch_cnt      <= '0;
            smp_cnt     <= '0;
            line_cnt    <= '0;
            frame_reset <= 1'b0;
        end else begin
            frame_reset <= 1'b0;
            if (abort_hit) begin
                state       <= IDLE;
                frame_reset <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (frame_start_req) state <= LOAD;
                    LOAD: begin
                        h_lat     <= max_h_count;
                        v_lat     <= max_v_count;
                        dummy_lat <= dummy_frame;
                        ch_cnt    <= '0;
                        smp_cnt   <= '0;
                        line_cnt  <= '0;
                        state     <= (max_h_count == '0 || max_v_count == '0) ? DONE : STREAM;
                    end
                    STREAM: if (xfer) begin
                        if (!last_smp) begin
                            smp_cnt <= smp_cnt + CNT_W'(1);
                        end else begin
                            smp_cnt <= '0;
                            if (!last_ch) begin
                                ch_cnt <= ch_cnt + CH_W'(1);
                            end else begin
                                ch_cnt <= '0;
                                if (last_line) state <= DRAIN;
                                else           line_cnt <= line_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DRAIN:   if (out_free) state <= DONE;
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Output register: loads on a transfer (unless dummy), drops valid once accepted.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tuser   <= 1'b0;
            m_axis_tdata_a <= '0;
            m_axis_tdata_b <= '0;
        end else if (abort_hit) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (xfer) begin
            if (!dummy_lat) begin
                m_axis_tvalid  <= 1'b1;
                m_axis_tdata_a <= ch_data_a[ch_cnt];
                m_axis_tdata_b <= ch_data_b[ch_cnt];
                m_axis_tuser   <= (line_cnt == '0) && (ch_cnt == '0) && (smp_cnt == '0);
                m_axis_tlast   <= last_ch && last_smp;
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
